// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller
//
// Round/match sequencer for the two-player fighter. Runs a best-of-N match
// of timed rounds: each round opens with a countdown, then a FIGHT phase that
// ends on a KO or when the round timer expires, then a short ROUND_END
// display phase. Win counts are kept per player. When a player reaches the
// required number of wins, or the round cap is hit, the match is over.
//
// Two hold-to-restart inputs share one restart sequence:
//   restart_btn  - only honoured once the match is over
//   force_reset  - honoured in every state, overrides any other transition
// Each must be held for HOLD_TICKS consecutive ticks and fires once per hold.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   reset_n      in   asynchronous active-low reset
//   tick         in   single-clk 20 Hz game tick enable
//   health_1     in   [HP_W]  player 1 health
//   health_2     in   [HP_W]  player 2 health
//   restart_btn  in   restart request (MATCH_OVER only)
//   force_reset  in   restart request (any state)
//   state        out  [3]  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER
//   fight_en     out  high only while in FIGHT
//   round_reset  out  one-clk pulse reinitialising positions, health, bullets
//   round_num    out  current round number, 1-based (0 only under reset)
//   wins_1       out  player 1 round wins
//   wins_2       out  player 2 round wins
//   round_winner out  [2] last round result: 00 none, 01 P1, 10 P2, 11 draw
//   winner       out  [2] match result, same encoding, non-zero in MATCH_OVER
//   time_left    out  FIGHT ticks remaining
// ---------------------------------------------------------------------------
module match_controller #(
  parameter int HP_W            = 9,
  parameter int ROUNDS_TO_WIN   = 2,
  parameter int MAX_ROUNDS      = 3,
  parameter int ROUND_TICKS     = 1200,
  parameter int COUNTDOWN_TICKS = 60,
  parameter int END_TICKS       = 40,
  parameter int HOLD_TICKS      = 40
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               tick,
  input  logic [HP_W-1:0]                    health_1,
  input  logic [HP_W-1:0]                    health_2,
  input  logic                               restart_btn,
  input  logic                               force_reset,
  output logic [2:0]                         state,
  output logic                               fight_en,
  output logic                               round_reset,
  output logic [$clog2(MAX_ROUNDS+1)-1:0]    round_num,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] wins_1,
  output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] wins_2,
  output logic [1:0]                         round_winner,
  output logic [1:0]                         winner,
  output logic [$clog2(ROUND_TICKS+1)-1:0]   time_left
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COUNTDOWN  = 3'd1;
  localparam logic [2:0] S_FIGHT      = 3'd2;
  localparam logic [2:0] S_ROUND_END  = 3'd3;
  localparam logic [2:0] S_MATCH_OVER = 3'd4;

  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam int RN_W = $clog2(MAX_ROUNDS + 1);
  localparam int WN_W = $clog2(ROUNDS_TO_WIN + 1);
  localparam int TL_W = $clog2(ROUND_TICKS + 1);

  // A zero-length end phase or hold would be meaningless; treat it as one
  // tick so the counters below never need a negative terminal value.
  localparam int END_EFF  = (END_TICKS  < 1) ? 1 : END_TICKS;
  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;

  // The countdown and end phases never overlap, so they share one counter
  // sized for the longer of the two.
  localparam int PH_MAX = (COUNTDOWN_TICKS > END_EFF) ? COUNTDOWN_TICKS : END_EFF;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int HOLD_W = $clog2(HOLD_EFF + 1);

  localparam logic [PH_W-1:0]   CD_LAST   = PH_W'(COUNTDOWN_TICKS - 1);
  localparam logic [PH_W-1:0]   END_LAST  = PH_W'(END_EFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_EFF);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_EFF - 1);
  localparam logic [TL_W-1:0]   TL_FULL   = TL_W'(ROUND_TICKS);
  localparam logic [RN_W-1:0]   RN_MAX    = RN_W'(MAX_ROUNDS);
  localparam logic [RN_W-1:0]   RN_FIRST  = RN_W'(1);
  localparam logic [WN_W-1:0]   WN_GOAL   = WN_W'(ROUNDS_TO_WIN);
  localparam logic [WN_W-1:0]   WN_ONE    = WN_W'(1);

  logic [PH_W-1:0]   phase_cnt;
  logic [HOLD_W-1:0] force_cnt;
  logic [HOLD_W-1:0] force_cnt_next;
  logic [HOLD_W-1:0] restart_cnt;
  logic [HOLD_W-1:0] restart_cnt_next;
  logic              force_fire;
  logic              restart_fire;
  logic              h1_zero;
  logic              h2_zero;
  logic              ko;
  logic              time_up;
  logic              round_over;
  logic [1:0]        timeout_code;
  logic [1:0]        result_code;

  assign fight_en = (state == S_FIGHT);

  // Round judgement. The KO code falls straight out of the two zero flags
  // (h1 dead -> P2 wins, h2 dead -> P1 wins, both -> draw). KO takes
  // priority over a timeout landing in the same cycle.
  always_comb begin
    h1_zero = (health_1 == '0);
    h2_zero = (health_2 == '0);
    ko      = h1_zero | h2_zero;
    if (health_1 > health_2) begin
      timeout_code = RES_P1;
    end else if (health_2 > health_1) begin
      timeout_code = RES_P2;
    end else begin
      timeout_code = RES_DRAW;
    end
    result_code = ko ? {h1_zero, h2_zero} : timeout_code;
    time_up     = (time_left == '0);
    round_over  = ko | time_up;
  end

  // Hold counters advance only on ticks and saturate at the hold length.
  // A restart fires on the single tick that takes a counter from one short
  // of full to full, so a held button fires exactly once until released.
  // The restart_btn counter only runs while the match is over.
  always_comb begin
    force_cnt_next = force_cnt;
    force_fire     = 1'b0;
    if (tick) begin
      if (!force_reset) begin
        force_cnt_next = '0;
      end else if (force_cnt != HOLD_FULL) begin
        force_cnt_next = force_cnt + HOLD_W'(1);
        force_fire     = (force_cnt == HOLD_LAST);
      end
    end

    restart_cnt_next = restart_cnt;
    restart_fire     = 1'b0;
    if (state != S_MATCH_OVER) begin
      restart_cnt_next = '0;
    end else if (tick) begin
      if (!restart_btn) begin
        restart_cnt_next = '0;
      end else if (restart_cnt != HOLD_FULL) begin
        restart_cnt_next = restart_cnt + HOLD_W'(1);
        restart_fire     = (restart_cnt == HOLD_LAST);
      end
    end
  end

  // Hold counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      force_cnt   <= '0;
      restart_cnt <= '0;
    end else begin
      force_cnt   <= force_cnt_next;
      restart_cnt <= restart_cnt_next;
    end
  end

  // Match sequencer. The restart sequence (also the exit from IDLE) sets up
  // round 1 and pulses round_reset; it takes precedence over every normal
  // transition so force_reset can never be lost to a coincident state change.
  // round_reset defaults low each cycle, so it is at most one clk wide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      round_reset  <= 1'b0;
      round_num    <= '0;
      wins_1       <= '0;
      wins_2       <= '0;
      round_winner <= 2'b00;
      winner       <= 2'b00;
      time_left    <= TL_FULL;
      phase_cnt    <= '0;
    end else begin
      round_reset <= 1'b0;
      if (force_fire || restart_fire || (state == S_IDLE)) begin
        state        <= S_COUNTDOWN;
        round_reset  <= 1'b1;
        round_num    <= RN_FIRST;
        wins_1       <= '0;
        wins_2       <= '0;
        round_winner <= 2'b00;
        winner       <= 2'b00;
        time_left    <= TL_FULL;
        phase_cnt    <= '0;
      end else begin
        case (state)
          // Health is deliberately ignored here so the health block has
          // settled after round_reset before any KO can be judged.
          S_COUNTDOWN: begin
            if (tick) begin
              if (phase_cnt == CD_LAST) begin
                state     <= S_FIGHT;
                time_left <= TL_FULL;
                phase_cnt <= '0;
              end else begin
                phase_cnt <= phase_cnt + PH_W'(1);
              end
            end
          end

          // KO is checked every clk; the timer expiring is seen the cycle
          // after the decrement that reached zero, so the decrement itself
          // can never wrap.
          S_FIGHT: begin
            if (round_over) begin
              round_winner <= result_code;
              if ((result_code == RES_P1) && (wins_1 != WN_GOAL)) begin
                wins_1 <= wins_1 + WN_ONE;
              end
              if ((result_code == RES_P2) && (wins_2 != WN_GOAL)) begin
                wins_2 <= wins_2 + WN_ONE;
              end
              state     <= S_ROUND_END;
              phase_cnt <= '0;
            end else if (tick) begin
              time_left <= time_left - TL_W'(1);
            end
          end

          // After the display hold, either the match is decided (by reaching
          // the win target or by running out of rounds) or the next round
          // is set up.
          S_ROUND_END: begin
            if (tick) begin
              if (phase_cnt == END_LAST) begin
                phase_cnt <= '0;
                if (wins_1 == WN_GOAL) begin
                  winner <= RES_P1;
                  state  <= S_MATCH_OVER;
                end else if (wins_2 == WN_GOAL) begin
                  winner <= RES_P2;
                  state  <= S_MATCH_OVER;
                end else if (round_num == RN_MAX) begin
                  if (wins_1 > wins_2) begin
                    winner <= RES_P1;
                  end else if (wins_2 > wins_1) begin
                    winner <= RES_P2;
                  end else begin
                    winner <= RES_DRAW;
                  end
                  state <= S_MATCH_OVER;
                end else begin
                  round_num   <= round_num + RN_FIRST;
                  round_reset <= 1'b1;
                  state       <= S_COUNTDOWN;
                end
              end else begin
                phase_cnt <= phase_cnt + PH_W'(1);
              end
            end
          end

          // Everything holds; only a restart leaves this state.
          S_MATCH_OVER: begin
            state <= S_MATCH_OVER;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller
//
// Bench for match_controller with short round timings. Directed scenarios
// follow a full match, timeouts, draws and both restart paths; a random
// phase drives arbitrary health, ticks and restart inputs. A reference model
// of the match rules, stepped once per clk, supplies the expected outputs.
// ---------------------------------------------------------------------------
module tb_match_controller;

  localparam int HP_W = 9;
  localparam int RTW  = 2;
  localparam int MAXR = 3;
  localparam int RT   = 10;
  localparam int CD   = 3;
  localparam int ET   = 2;
  localparam int HT   = 4;

  localparam int RN_W  = $clog2(MAXR + 1);
  localparam int WN_W  = $clog2(RTW + 1);
  localparam int TL_W  = $clog2(RT + 1);
  localparam int VEC_W = 3 + 1 + 1 + RN_W + 2 * WN_W + 2 + 2 + TL_W;

  localparam int M_IDLE = 0, M_CD = 1, M_FIGHT = 2, M_END = 3, M_OVER = 4;

  localparam logic [VEC_W-1:0] RESET_VEC =
    {3'd0, 1'b0, 1'b0, RN_W'(0), WN_W'(0), WN_W'(0), 2'd0, 2'd0, TL_W'(RT)};

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            tick = 1'b0;
  logic [HP_W-1:0] health_1 = 9'd100;
  logic [HP_W-1:0] health_2 = 9'd100;
  logic            restart_btn = 1'b0;
  logic            force_reset = 1'b0;

  logic [2:0]      state;
  logic            fight_en;
  logic            round_reset;
  logic [RN_W-1:0] round_num;
  logic [WN_W-1:0] wins_1;
  logic [WN_W-1:0] wins_2;
  logic [1:0]      round_winner;
  logic [1:0]      winner;
  logic [TL_W-1:0] time_left;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic saw_rr;

  // Reference model: the match as seen by a referee.
  int   m_state, m_round, m_w1, m_w2, m_rw, m_win, m_tl, m_phase;
  int   m_force_held, m_restart_held;
  logic m_rr;

  logic [VEC_W-1:0] dut_vec;
  logic [VEC_W-1:0] mdl_vec;

  assign dut_vec = {state, fight_en, round_reset, round_num, wins_1, wins_2,
                    round_winner, winner, time_left};
  assign mdl_vec = {3'(m_state), (m_state == M_FIGHT), m_rr, RN_W'(m_round),
                    WN_W'(m_w1), WN_W'(m_w2), 2'(m_rw), 2'(m_win), TL_W'(m_tl)};

  match_controller #(
    .HP_W(HP_W), .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR), .ROUND_TICKS(RT),
    .COUNTDOWN_TICKS(CD), .END_TICKS(ET), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .health_1(health_1), .health_2(health_2),
    .restart_btn(restart_btn), .force_reset(force_reset),
    .state(state), .fight_en(fight_en), .round_reset(round_reset),
    .round_num(round_num), .wins_1(wins_1), .wins_2(wins_2),
    .round_winner(round_winner), .winner(winner), .time_left(time_left)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = M_IDLE; m_round = 0; m_w1 = 0; m_w2 = 0; m_rw = 0; m_win = 0;
    m_tl = RT; m_phase = 0; m_force_held = 0; m_restart_held = 0; m_rr = 1'b0;
  endtask

  task automatic model_new_match();
    m_state = M_CD; m_round = 1; m_w1 = 0; m_w2 = 0; m_rw = 0; m_win = 0;
    m_tl = RT; m_phase = 0; m_rr = 1'b1;
  endtask

  task automatic model_score(input int res);
    m_rw = res;
    if (res == 1) m_w1 = m_w1 + 1;
    if (res == 2) m_w2 = m_w2 + 1;
    m_state = M_END;
    m_phase = 0;
  endtask

  // One clk of the match rules, using the inputs present at the edge.
  task automatic model_step();
    logic restart;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rr = 1'b0;
      restart = 1'b0;
      if (tick) begin
        if (!force_reset) m_force_held = 0;
        else if (m_force_held < HT) begin
          m_force_held = m_force_held + 1;
          if (m_force_held == HT) restart = 1'b1;
        end
      end
      if (m_state != M_OVER) m_restart_held = 0;
      else if (tick) begin
        if (!restart_btn) m_restart_held = 0;
        else if (m_restart_held < HT) begin
          m_restart_held = m_restart_held + 1;
          if (m_restart_held == HT) restart = 1'b1;
        end
      end
      if (restart || m_state == M_IDLE) begin
        model_new_match();
      end else if (m_state == M_CD) begin
        if (tick) begin
          m_phase = m_phase + 1;
          if (m_phase == CD) begin m_state = M_FIGHT; m_tl = RT; m_phase = 0; end
        end
      end else if (m_state == M_FIGHT) begin
        if (health_1 == 0 && health_2 == 0) model_score(3);
        else if (health_1 == 0) model_score(2);
        else if (health_2 == 0) model_score(1);
        else if (m_tl == 0) model_score(health_1 > health_2 ? 1 : (health_2 > health_1 ? 2 : 3));
        else if (tick) m_tl = m_tl - 1;
      end else if (m_state == M_END) begin
        if (tick) begin
          m_phase = m_phase + 1;
          if (m_phase == ET) begin
            m_phase = 0;
            if (m_w1 == RTW) begin m_win = 1; m_state = M_OVER; end
            else if (m_w2 == RTW) begin m_win = 2; m_state = M_OVER; end
            else if (m_round == MAXR) begin
              m_win = (m_w1 > m_w2) ? 1 : ((m_w2 > m_w1) ? 2 : 3);
              m_state = M_OVER;
            end else begin
              m_round = m_round + 1; m_rr = 1'b1; m_state = M_CD;
            end
          end
        end
      end
    end
  endtask

  // Called at a negedge: apply tick, advance one clk, return at the next negedge.
  task automatic cycle(input logic t);
    tick = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_tick();
    cycle(1'b1);
    saw_rr = round_reset;
    cycle(1'b0);
    cycle(1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    cycle(1'b0);
    n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("[TB] FAIL reset_values: got %h expected %h", dut_vec, RESET_VEC); end
    n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL reset_model: got %h expected %h", dut_vec, mdl_vec); end
    reset_n = 1'b1;
    cycle(1'b0);
    n_tests++; if (round_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL start_round_reset: got %0d expected 1", round_reset); end
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("[TB] FAIL start_state: got %0d expected 1", state); end
    n_tests++; if (round_num !== RN_W'(1)) begin n_fail++; $display("[TB] FAIL start_round_num: got %0d expected 1", round_num); end
    cycle(1'b0);
    n_tests++; if (round_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL round_reset_width: got %0d expected 0", round_reset); end
  endtask

  task automatic test_countdown();
    for (int i = 1; i <= CD; i++) begin
      do_tick();
      if (i < CD) begin
        n_tests++; if (state !== 3'd1) begin n_fail++; $display("[TB] FAIL countdown_hold t%0d: got %0d expected 1", i, state); end
      end
    end
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL fight_entry: got %0d expected 2", state); end
    n_tests++; if (time_left !== TL_W'(RT)) begin n_fail++; $display("[TB] FAIL fight_time_left: got %0d expected %0d", time_left, RT); end
    n_tests++; if (fight_en !== 1'b1) begin n_fail++; $display("[TB] FAIL fight_en_high: got %0d expected 1", fight_en); end
  endtask

  task automatic test_ko();
    do_tick();
    health_2 = 9'd0;
    cycle(1'b0);
    n_tests++; if (round_winner !== 2'b01) begin n_fail++; $display("[TB] FAIL ko_round_winner: got %0d expected 1", round_winner); end
    n_tests++; if (wins_1 !== WN_W'(1)) begin n_fail++; $display("[TB] FAIL ko_wins_1: got %0d expected 1", wins_1); end
    n_tests++; if (fight_en !== 1'b0) begin n_fail++; $display("[TB] FAIL ko_fight_en: got %0d expected 0", fight_en); end
    n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL ko_model: got %h expected %h", dut_vec, mdl_vec); end
    health_2 = 9'd100;
    do_tick();
    n_tests++; if (state !== 3'd3) begin n_fail++; $display("[TB] FAIL end_hold: got %0d expected 3", state); end
    do_tick();
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("[TB] FAIL next_round_state: got %0d expected 1", state); end
    n_tests++; if (round_num !== RN_W'(2)) begin n_fail++; $display("[TB] FAIL next_round_num: got %0d expected 2", round_num); end
    n_tests++; if (saw_rr !== 1'b1) begin n_fail++; $display("[TB] FAIL next_round_reset: got %0d expected 1", saw_rr); end
  endtask

  task automatic test_match_restart();
    for (int i = 0; i < CD; i++) do_tick();
    health_2 = 9'd0;
    cycle(1'b0);
    health_2 = 9'd100;
    for (int i = 0; i < ET; i++) do_tick();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("[TB] FAIL match_over_state: got %0d expected 4", state); end
    n_tests++; if (winner !== 2'b01) begin n_fail++; $display("[TB] FAIL match_winner_p1: got %0d expected 1", winner); end
    restart_btn = 1'b1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    n_tests++; if (state !== 3'd4) begin n_fail++; $display("[TB] FAIL restart_short_hold: got %0d expected 4", state); end
    cycle(1'b1);
    n_tests++; if (round_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_pulse: got %0d expected 1", round_reset); end
    n_tests++; if (wins_1 !== WN_W'(0)) begin n_fail++; $display("[TB] FAIL restart_wins: got %0d expected 0", wins_1); end
    n_tests++; if (round_num !== RN_W'(1)) begin n_fail++; $display("[TB] FAIL restart_round_num: got %0d expected 1", round_num); end
    n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL restart_model: got %h expected %h", dut_vec, mdl_vec); end
    restart_btn = 1'b0;
    cycle(1'b0);
  endtask

  task automatic test_timeout();
    health_1 = 9'd50; health_2 = 9'd50;
    for (int i = 0; i < CD + 5; i++) do_tick();
    n_tests++; if (time_left !== TL_W'(RT - 5)) begin n_fail++; $display("[TB] FAIL time_left_mid: got %0d expected %0d", time_left, RT - 5); end
    for (int i = 0; i < RT - 5; i++) do_tick();
    n_tests++; if (round_winner !== 2'b11) begin n_fail++; $display("[TB] FAIL timeout_draw: got %0d expected 3", round_winner); end
    n_tests++; if ({wins_1, wins_2} !== {WN_W'(0), WN_W'(0)}) begin n_fail++; $display("[TB] FAIL timeout_draw_wins: got %0d/%0d expected 0/0", wins_1, wins_2); end
    n_tests++; if (time_left !== TL_W'(0)) begin n_fail++; $display("[TB] FAIL timeout_floor: got %0d expected 0", time_left); end
    for (int i = 0; i < ET; i++) do_tick();
    health_1 = 9'd60; health_2 = 9'd40;
    for (int i = 0; i < CD + RT; i++) do_tick();
    n_tests++; if (round_winner !== 2'b01) begin n_fail++; $display("[TB] FAIL timeout_p1: got %0d expected 1", round_winner); end
    n_tests++; if (wins_1 !== WN_W'(1)) begin n_fail++; $display("[TB] FAIL timeout_p1_wins: got %0d expected 1", wins_1); end
    for (int i = 0; i < ET; i++) do_tick();
    n_tests++; if (round_num !== RN_W'(3)) begin n_fail++; $display("[TB] FAIL timeout_round3: got %0d expected 3", round_num); end
  endtask

  task automatic test_force_reset();
    for (int i = 0; i < CD; i++) do_tick();
    force_reset = 1'b1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL force_short_hold: got %0d expected 2", state); end
    cycle(1'b1);
    n_tests++; if (round_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL force_pulse: got %0d expected 1", round_reset); end
    n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL force_model: got %h expected %h", dut_vec, mdl_vec); end
    cycle(1'b0);
    for (int i = 0; i < 2; i++) begin
      do_tick();
      n_tests++; if (saw_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL force_once %0d: got %0d expected 0", i, saw_rr); end
    end
    force_reset = 1'b0;
    do_tick();
    force_reset = 1'b1;
    for (int i = 0; i < HT - 1; i++) do_tick();
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL force_recount: got %0d expected 2", state); end
    cycle(1'b1);
    n_tests++; if (state !== 3'd1 || round_reset !== 1'b1) begin n_fail++; $display("[TB] FAIL force_second: got state %0d rr %0d expected 1 1", state, round_reset); end
    force_reset = 1'b0;
    cycle(1'b0);
  endtask

  task automatic test_draw_sequence();
    health_1 = 9'd100; health_2 = 9'd100;
    for (int i = 0; i < CD; i++) do_tick();
    health_2 = 9'd0; cycle(1'b0); health_2 = 9'd100;
    for (int i = 0; i < ET + CD; i++) do_tick();
    health_1 = 9'd0; cycle(1'b0); health_1 = 9'd100;
    n_tests++; if (round_winner !== 2'b10) begin n_fail++; $display("[TB] FAIL p2_round: got %0d expected 2", round_winner); end
    for (int i = 0; i < ET + CD; i++) do_tick();
    health_1 = 9'd0; health_2 = 9'd0; cycle(1'b0);
    n_tests++; if (round_winner !== 2'b11) begin n_fail++; $display("[TB] FAIL double_ko: got %0d expected 3", round_winner); end
    health_1 = 9'd100; health_2 = 9'd100;
    for (int i = 0; i < ET; i++) do_tick();
    n_tests++; if (state !== 3'd4 || winner !== 2'b11) begin n_fail++; $display("[TB] FAIL match_draw: got state %0d winner %0d expected 4 3", state, winner); end
    n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL draw_model: got %h expected %h", dut_vec, mdl_vec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (i % 6 == 0) begin
        health_1 = ($urandom_range(0, 11) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        health_2 = ($urandom_range(0, 11) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        if ($urandom_range(0, 3) == 0) health_2 = health_1;
      end
      if ($urandom_range(0, 24) == 0) restart_btn = ~restart_btn;
      if ($urandom_range(0, 79) == 0) force_reset = ~force_reset;
      cycle($urandom_range(0, 2) == 0);
      n_tests++; if (dut_vec !== mdl_vec) begin n_fail++; $display("[TB] FAIL random_model cyc%0d: got %h expected %h", i, dut_vec, mdl_vec); end
    end
    restart_btn = 1'b0; force_reset = 1'b0;
    health_1 = 9'd100; health_2 = 9'd100;
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0;
    model_reset();
    cycle(1'b0);
    reset_n = 1'b1;
    cycle(1'b0);
    for (int i = 0; i < CD + 2; i++) do_tick();
    n_tests++; if (state !== 3'd2) begin n_fail++; $display("[TB] FAIL pre_async_state: got %0d expected 2", state); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (dut_vec !== RESET_VEC) begin n_fail++; $display("[TB] FAIL async_reset: got %h expected %h", dut_vec, RESET_VEC); end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_ko();
    test_match_restart();
    test_timeout();
    test_force_reset();
    test_draw_sequence();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
